// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - RISC-V execute stage: ALU compute into a 2-entry skid buffer
module alu_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [4:0]      rd_out,
    output logic            illegal_op
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    logic [1:0]      state;
    logic [1:0]      next_state;

    logic [XLEN-1:0] c_result;
    logic            c_zero;
    logic            c_illegal;

    logic [XLEN-1:0] h_result, s_result;
    logic            h_zero, s_zero;
    logic [4:0]      h_rd, s_rd;
    logic            h_illegal, s_illegal;

    logic            accept;
    logic            emit;

    // Illegal codes force zero low so a bad op can never resolve a branch as taken.
    always_comb begin
        c_result  = '0;
        c_illegal = 1'b0;
        case (alu_ctrl)
            OP_AND:  c_result = op_a & op_b;
            OP_OR:   c_result = op_a | op_b;
            OP_ADD:  c_result = op_a + op_b;
            OP_SUB:  c_result = op_a - op_b;
            default: c_illegal = 1'b1;
        endcase
        c_zero = !c_illegal && (c_result == '0);
    end

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) next_state = ST_ONE;
                ST_ONE: begin
                    if (accept && !emit)      next_state = ST_TWO;
                    else if (!accept && emit) next_state = ST_EMPTY;
                end
                ST_TWO:   if (emit) next_state = ST_ONE;
                default:  next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != ST_TWO);
        end
    end

    // Data registers keep their contents across flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_result  <= '0;
            h_zero    <= 1'b0;
            h_rd      <= '0;
            h_illegal <= 1'b0;
            s_result  <= '0;
            s_zero    <= 1'b0;
            s_rd      <= '0;
            s_illegal <= 1'b0;
        end else if (!flush) begin
            if ((state == ST_EMPTY && accept) || (state == ST_ONE && accept && emit)) begin
                h_result  <= c_result;
                h_zero    <= c_zero;
                h_rd      <= rd_in;
                h_illegal <= c_illegal;
            end else if (state == ST_TWO && emit) begin
                h_result  <= s_result;
                h_zero    <= s_zero;
                h_rd      <= s_rd;
                h_illegal <= s_illegal;
            end
            if (state == ST_ONE && accept && !emit) begin
                s_result  <= c_result;
                s_zero    <= c_zero;
                s_rd      <= rd_in;
                s_illegal <= c_illegal;
            end
        end
    end

    assign result     = h_result;
    assign zero       = h_zero;
    assign rd_out     = h_rd;
    assign illegal_op = h_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage against a queue model
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd_out;
    logic        illegal_op;

    int n_checks = 0;
    int n_pass   = 0;
    logic acc;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    entry_t exp_q[$];

    alu_exec_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .rd_out(rd_out), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic entry_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] rd);
        entry_t e;
        e.rd  = rd;
        e.ill = 1'b0;
        e.res = 32'd0;
        case (c)
            4'd0:    e.res = a & b;
            4'd1:    e.res = a | b;
            4'd2:    e.res = a + b;
            4'd6:    e.res = a - b;
            default: e.ill = 1'b1;
        endcase
        e.z = !e.ill && (e.res == 32'd0);
        return e;
    endfunction

    // Drives one cycle of inputs at a negedge, advances the model, returns at the next negedge.
    task automatic drive(input logic iv, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic ordy, input logic fl, output logic acc_o);
        logic emi;
        acc_o = iv && (exp_q.size() < 2);
        emi   = ordy && (exp_q.size() > 0);
        in_valid = iv; alu_ctrl = c; op_a = a; op_b = b; rd_in = rd; out_ready = ordy; flush = fl;
        if (emi) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (acc_o) exp_q.push_back(model(c, a, b, rd));
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, result, zero, rd_out, illegal_op} !== {1'b0, 1'b1, 32'd0, 1'b0, 5'd0, 1'b0})
            $display("FAIL reset_state got v=%b r=%b res=%h z=%b rd=%0d ill=%b exp v=0 r=1 res=0 z=0 rd=0 ill=0",
                     out_valid, in_ready, result, zero, rd_out, illegal_op);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [3:0]  tc [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd2, 4'd6};
        logic [31:0] ta [6] = '{32'd5, 32'd9, 32'hF0F0_F0F0, 32'h1, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] tb [6] = '{32'd7, 32'd9, 32'h0FF0_0FF0, 32'h8, 32'd1, 32'd1};
        logic [31:0] tr [6] = '{32'd12, 32'd0, 32'h00F0_00F0, 32'h9, 32'd0, 32'hFFFF_FFFF};
        logic        tz [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tc[i], ta[i], tb[i], 5'(i + 10), 1'b1, 1'b0, acc);
            n_checks++;
            if ({out_valid, result, zero, rd_out, illegal_op} !== {1'b1, tr[i], tz[i], 5'(i + 10), 1'b0})
                $display("FAIL single_op_%0d got v=%b res=%h z=%b rd=%0d ill=%b exp v=1 res=%h z=%b rd=%0d ill=0",
                         i, out_valid, result, zero, rd_out, illegal_op, tr[i], tz[i], i + 10);
            else n_pass++;
        end
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, acc);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_drain got out_valid=%b exp 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_illegal();
        drive(1'b1, 4'hF, 32'd0, 32'd0, 5'd3, 1'b1, 1'b0, acc);
        n_checks++;
        if ({out_valid, result, zero, illegal_op} !== {1'b1, 32'd0, 1'b0, 1'b1})
            $display("FAIL illegal_op got v=%b res=%h z=%b ill=%b exp v=1 res=0 z=0 ill=1",
                     out_valid, result, zero, illegal_op);
        else n_pass++;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_back_to_back();
        logic [4:0] got[$];
        logic       pend;
        for (int i = 1; i <= 3; i++)
            drive(1'b1, 4'd2, 32'(i), 32'd100, 5'(i), 1'b0, 1'b0, acc);
        n_checks++;
        if ({in_ready, out_valid, rd_out} !== {1'b0, 1'b1, 5'd1})
            $display("FAIL backpressure_full got in_ready=%b v=%b rd=%0d exp in_ready=0 v=1 rd=1",
                     in_ready, out_valid, rd_out);
        else n_pass++;
        pend = 1'b1;
        for (int cyc = 0; cyc < 12 && (pend || exp_q.size() > 0); cyc++) begin
            if (out_valid) got.push_back(rd_out);
            drive(pend, 4'd2, 32'd3, 32'd100, 5'd3, 1'b1, 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        if (out_valid) got.push_back(rd_out);
        n_checks++;
        if (got.size() != 3 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3)
            $display("FAIL backpressure_order got %p exp '{1,2,3}", got);
        else n_pass++;
    endtask

    task automatic test_flush();
        drive(1'b1, 4'd2, 32'd1, 32'd1, 5'd4, 1'b0, 1'b0, acc);
        drive(1'b1, 4'd2, 32'd2, 32'd2, 5'd5, 1'b0, 1'b0, acc);
        drive(1'b1, 4'd2, 32'd3, 32'd3, 5'd6, 1'b0, 1'b1, acc);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL flush_two got v=%b in_ready=%b exp v=0 in_ready=1", out_valid, in_ready);
        else n_pass++;
        // Accept handshake in ONE coinciding with flush must be dropped.
        drive(1'b1, 4'd2, 32'd7, 32'd0, 5'd7, 1'b0, 1'b0, acc);
        drive(1'b1, 4'd2, 32'd8, 32'd0, 5'd8, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b0)
                $display("FAIL flush_dropped cycle %0d got v=%b rd=%0d exp v=0", i, out_valid, rd_out);
            else n_pass++;
            drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, acc);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'd2, 32'd3, 32'd4, 5'd9, 1'b0, 1'b0, acc);
        drive(1'b1, 4'd2, 32'd5, 32'd4, 5'd10, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, result, rd_out} !== {1'b0, 1'b1, 32'd0, 5'd0})
            $display("FAIL async_reset got v=%b in_ready=%b res=%h rd=%0d exp v=0 in_ready=1 res=0 rd=0",
                     out_valid, in_ready, result, rd_out);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] codes [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd0};
        logic [3:0] c;
        for (int i = 0; i < 400; i++) begin
            n_checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2))
                $display("FAIL random_ctrl cycle %0d got v=%b in_ready=%b exp v=%b in_ready=%b",
                         i, out_valid, in_ready, exp_q.size() > 0, exp_q.size() < 2);
            else n_pass++;
            if (exp_q.size() > 0) begin
                n_checks++;
                if ({result, zero, rd_out, illegal_op} !== {exp_q[0].res, exp_q[0].z, exp_q[0].rd, exp_q[0].ill})
                    $display("FAIL random_data cycle %0d got res=%h z=%b rd=%0d ill=%b exp res=%h z=%b rd=%0d ill=%b",
                             i, result, zero, rd_out, illegal_op,
                             exp_q[0].res, exp_q[0].z, exp_q[0].rd, exp_q[0].ill);
                else n_pass++;
            end
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 3)];
            drive(1'($urandom_range(0, 3) != 0), c,
                  ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom,
                  ($urandom_range(0, 5) == 0) ? 32'd1 : $urandom,
                  5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0), acc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the RISC-V datapath, directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit ALU operation code together with the two operands and the destination register.
- Computes the ALU result and the branch zero flag, and registers them into a 2-entry skid buffer.
- Uses valid/ready handshakes on both sides, so the memory stage can stall without a combinational ready path.

Parameters:
XLEN, 32, operand and result width in bits.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset; asynchronous assert, active-low.
flush  input  1  synchronous kill of all buffered entries (branch mispredict).
in_valid  input  1  upstream has a valid operation.
in_ready  output  1  stage can accept; registered.
alu_ctrl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB; all other codes are illegal.
op_a  input  XLEN  operand A.
op_b  input  XLEN  operand B.
rd_in  input  5  destination register index, passed through.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head entry.
result  output  XLEN  head entry ALU result.
zero  output  1  head entry result == 0.
rd_out  output  5  head entry destination index.
illegal_op  output  1  head entry carried an undefined alu_ctrl code.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both entries invalid, state EMPTY.
  - out_valid=0, in_ready=1, result=0, zero=0, rd_out=0, illegal_op=0.
- Compute (combinational, at the input side):
  - AND and OR are bitwise.
  - ADD is op_a+op_b and SUB is op_a-op_b, both modulo 2^XLEN; carry/borrow is discarded.
  - Illegal code: result=0, zero=0, illegal_op=1. zero is forced 0 so a bad op never takes a branch.
  - Legal code: illegal_op=0 and zero=(result==0).
- Handshakes:
  - Accept occurs when in_valid && in_ready at a clock edge.
  - Emit occurs when out_valid && out_ready at a clock edge.
  - Inputs are sampled only on accept.
  - Outputs remain stable while out_valid && !out_ready.
- Storage: head register H drives the outputs; skid register S holds the second entry.
- State machine (count of valid entries):
  - EMPTY:
    - accept -> ONE, H loaded.
    - Otherwise stay.
  - ONE:
    - accept and emit -> ONE, H reloaded with new entry.
    - accept, no emit -> TWO, S loaded.
    - emit, no accept -> EMPTY.
    - Neither -> stay.
  - TWO:
    - in_ready=0, so no accept is possible.
    - emit -> ONE, H<=S.
    - Otherwise stay.
- in_ready is registered and equals (next_state != TWO). It is 1 in EMPTY and ONE, 0 in TWO.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 op/cycle when out_ready is held high.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- flush:
  - Next state EMPTY and out_valid=0 on the next cycle; in_ready=1 on the next cycle.
  - An accept in the same cycle is dropped; flush wins.
  - An emit in the same cycle still completes, because downstream already saw valid.
- Reset mid-operation discards all entries immediately, independent of clk.
- Output data registers hold their last value when invalid; they are cleared only by reset.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, result=0, zero=0, illegal_op=0.
- Single ops, out_ready=1:
  - ADD 5+7 -> result=12, zero=0, one cycle later.
  - SUB 9-9 -> result=0, zero=1.
  - AND 0xF0F0_F0F0 & 0x0FF0_0FF0 -> 0x00F0_00F0.
  - OR 0x1 | 0x8 -> 0x9.
- Wrap-around:
  - ADD 0xFFFF_FFFF+1 -> result=0, zero=1.
  - SUB 0-1 -> 0xFFFF_FFFF, zero=0.
- Backpressure:
  - Hold out_ready=0 and offer 3 back-to-back ops with rd=1,2,3 -> ops 1 and 2 accepted, in_ready=0, op 3 held.
  - Release out_ready -> rd_out sequence 1,2,3, with no loss or duplication.
- Illegal code: alu_ctrl=4'b1111 with op_a=op_b=0 -> result=0, zero=0, illegal_op=1.
- Flush:
  - In state TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1.
  - The flushed-cycle op never appears at the output.
  - Async rst_n pulse mid-stream -> outputs reset immediately, without waiting for a clock edge.
